// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side strobe bundle for the load/store unit.
interface load_store_unit_if #(parameter int MEM_AW = 9);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-wide memory; sub-word stores are
// done as read-modify-write.
module load_store_unit #(
  parameter int DEPTH_WORDS = 128,
  parameter int MEM_AW      = 9
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  ofs;
    logic [15:0] wlo;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic              done_q, done_d, err_q, err_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0]       rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  // Request legality is judged on the live inputs so the error path can go
  // straight to RESP from the accept edge.
  logic bad_code, misalign, oob, acc_err;
  always_comb begin
    bad_code = bus.we ? (bus.funct3 > 3'b010)
                      : (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11);
    misalign = (bus.funct3[1:0] == 2'b01 && bus.addr[0]) ||
               (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
    oob      = {2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS);
    acc_err  = bad_code || misalign || oob;
  end

  // Legal halves and words have offsets 0/2 and 0, so one byte-granular shift
  // serves every load width.
  logic [31:0] rd_sh, ld_val;
  assign rd_sh = bus.mem_rdata >> {req_q.ofs, 3'b000};
  always_comb begin
    case (req_q.funct3)
      3'b000:  ld_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_val = {24'h0, rd_sh[7:0]};
      3'b101:  ld_val = {16'h0, rd_sh[15:0]};
      default: ld_val = rd_sh;
    endcase
  end

  logic [3:0]  be;
  logic [31:0] merged;
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] K = 2'(k);
    assign be[k] = req_q.funct3[0] ? (K[1] == req_q.ofs[1]) : (K == req_q.ofs);
    assign merged[8*k +: 8] = !be[k]          ? bus.mem_rdata[8*k +: 8] :
                              req_q.funct3[0] ? req_q.wlo[8*(k%2) +: 8] :
                                                req_q.wlo[7:0];
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        req_d      = '{we: bus.we, funct3: bus.funct3, ofs: bus.addr[1:0], wlo: bus.wdata[15:0]};
        mem_addr_d = bus.addr[MEM_AW+1:2];
        if (acc_err) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (bus.we && bus.funct3 == 3'b010) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_wdata_d = bus.wdata;
        end else begin
          state_d    = RD;
          mem_read_d = 1'b1;
        end
      end
      RD: if (req_q.we) begin
        state_d     = WR;
        mem_write_d = 1'b1;
        mem_wdata_d = merged;
      end else begin
        state_d = RESP;
        done_d  = 1'b1;
        rdata_d = ld_val;
      end
      WR: begin
        state_d = RESP;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Random and directed accesses against a word-array reference of the attached
// memory and the architectural load/store rules.
module tb_load_store_unit;
  localparam int DEPTH = 128;
  localparam int AW    = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.MEM_AW(AW)) bus ();
  load_store_unit #(.DEPTH_WORDS(DEPTH), .MEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // Attached memory: combinational read, level-sensitive write.
  logic [31:0] mem [DEPTH];
  logic        do_init = 1'b1;
  always @(bus.mem_write, bus.mem_addr, bus.mem_wdata, do_init) begin
    if (do_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    end else if (bus.mem_write && int'(bus.mem_addr) < DEPTH) begin
      mem[bus.mem_addr] = bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = (int'(bus.mem_addr) < DEPTH) ? mem[bus.mem_addr] : 32'h0;

  // Reference state
  logic [31:0] rmem [DEPTH];
  logic [31:0] ref_rdata;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input bit w, input logic [2:0] f, input logic [31:0] a);
    bit legal, half, word;
    legal = w ? (f <= 3'd2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
    half  = (f == 1 || f == 5);
    word  = (f == 2);
    return !legal || (half && a % 2 != 0) || (word && a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] f, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (8 * (a % 4))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    if (f == 3'd2) return d;
    sh = (f == 3'd0) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
    m  = ((f == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  task automatic drive_req(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    bit e;
    int lat, enrd, enwr, got_lat, nrd, nwr, both, ndone;
    logic [31:0] exp_wd, got_err, got_rd, seen_addr, seen_wd;
    int wi;
    wi = int'(a / 4);
    e = ref_err(w, f, a);
    exp_wd = 32'h0;
    if (e)                      begin lat = 1; enrd = 0; enwr = 0; end
    else if (!w)                begin lat = 2; enrd = 1; enwr = 0; ref_rdata = ld_ext(rmem[wi], f, a); end
    else if (f == 3'd2)         begin lat = 2; enrd = 0; enwr = 1; exp_wd = d; end
    else                        begin lat = 3; enrd = 1; enwr = 1; exp_wd = st_merge(rmem[wi], f, a, d); end
    got_lat = 0; nrd = 0; nwr = 0; both = 0; ndone = 0;
    got_err = 'x; got_rd = 'x; seen_addr = 'x; seen_wd = 'x;
    drive_req(w, f, a, d);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (bus.mem_read)  begin nrd++; seen_addr = 32'(bus.mem_addr); end
      if (bus.mem_write) begin nwr++; seen_addr = 32'(bus.mem_addr); seen_wd = bus.mem_wdata; end
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.done) begin
        ndone++;
        if (got_lat == 0) begin got_lat = n; got_err = 32'(bus.err); got_rd = bus.rdata; end
      end
    end
    chk({tag, "_lat"},   32'(got_lat), 32'(lat));
    chk({tag, "_err"},   got_err, 32'(e));
    chk({tag, "_rdata"}, got_rd, ref_rdata);
    chk({tag, "_nrd"},   32'(nrd), 32'(enrd));
    chk({tag, "_nwr"},   32'(nwr), 32'(enwr));
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    chk({tag, "_both"},  32'(both), 32'd0);
    chk({tag, "_idle"},  32'(bus.busy), 32'd0);
    if (!e) chk({tag, "_maddr"}, seen_addr, 32'(wi));
    if (!e && w) begin
      chk({tag, "_wdata"}, seen_wd, exp_wd);
      rmem[wi] = exp_wd;
    end
  endtask

  initial begin
    int last, nd;
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) rmem[i] = 32'(i);
    ref_rdata = 32'h0;
    #1 do_init = 1'b0;
    #2;
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_err",   32'(bus.err), 0);
    chk("rst_strb",  32'({bus.mem_read, bus.mem_write}), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_maddr", 32'(bus.mem_addr), 0);
    chk("rst_mwd",   bus.mem_wdata, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_op("lw14",  0, 3'd2, 32'h14, 32'h0);
    do_op("sb09",  1, 3'd0, 32'h09, 32'hAB);
    do_op("lb09",  0, 3'd0, 32'h09, 32'h0);
    do_op("lbu09", 0, 3'd4, 32'h09, 32'h0);
    do_op("lh0a",  0, 3'd1, 32'h0A, 32'h0);
    do_op("lhu08", 0, 3'd5, 32'h08, 32'h0);
    do_op("lw06",  0, 3'd2, 32'h06, 32'h0);
    do_op("sh03",  1, 3'd1, 32'h03, 32'h1234);
    do_op("f011",  0, 3'd3, 32'h00, 32'h0);
    do_op("lw200", 0, 3'd2, 32'h200, 32'h0);

    // Reset landing in the write cycle of an sh read-modify-write
    drive_req(1, 3'd1, 32'h04, 32'hBEEF);
    @(posedge clk); #2;
    chk("rst_in_wr", 32'(bus.mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write}), 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    chk("mid_rst_maddr", 32'(bus.mem_addr), 0);
    chk("mid_rst_mwd", bus.mem_wdata, 0);
    rmem[1] = st_merge(rmem[1], 3'd1, 32'h04, 32'hBEEF);
    ref_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 3; n++) begin @(negedge clk); nd += int'(bus.done); end
    chk("post_rst_done", 32'(nd), 0);
    do_op("lw04", 0, 3'd2, 32'h04, 32'h0);

    // req held high: one done per access, accesses spaced by full latency
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'd2; bus.addr = 32'h14; bus.wdata = 32'h0;
    last = -1; nd = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last >= 0) chk("hold_gap", 32'(n - last), 3);
        chk("hold_rdata", bus.rdata, rmem[5]);
        last = n; nd++;
      end
      chk("hold_both", 32'(bus.mem_read && bus.mem_write), 0);
    end
    bus.req = 1'b0;
    chk("hold_cnt", 32'(nd >= 9), 1);
    for (int n = 0; n < 6 && bus.busy; n++) @(negedge clk);
    chk("hold_drain", 32'(bus.busy), 0);
    ref_rdata = rmem[5];

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a, d;
      bit w;
      logic [2:0] f;
      w = 1'($urandom);
      f = 3'($urandom_range(0, 7));
      a = {$urandom_range(0, DEPTH + 3), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) a = $urandom;
      d = $urandom;
      do_op("rnd", w, f, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128, number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter MEM_AW, default 9, width of the memory word-address port.
REQ-003 SHALL have one clock and an asynchronous, active-low reset. Ports below are listed as name, direction, width, meaning.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  1  core access request, sampled only while busy=0.
REQ-007 we  input  1  1=store, 0=load; sampled with req.
REQ-008 funct3  input  3  RISC-V width/sign code; sampled with req.
REQ-009 addr  input  32  byte address; sampled with req.
REQ-010 wdata  input  32  store data, right-aligned; sampled with req.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  high with done when the access was rejected.
REQ-014 rdata  output  32  extended load result; holds until the next successful load completes.
REQ-015 mem_read  output  1  memory read strobe.
REQ-016 mem_write  output  1  memory write strobe; the memory writes level-sensitively while it is high.
REQ-017 mem_addr  output  MEM_AW  word index, equal to the captured addr[MEM_AW+1:2].
REQ-018 mem_wdata  output  32  full word to write.
REQ-019 mem_rdata  input  32  combinational read data from memory.

Function
REQ-020 SHALL implement the FSM states IDLE, RD, WR and RESP; busy=(state!=IDLE).
REQ-021 In IDLE, req=1 SHALL capture we, funct3, addr and wdata at the clock edge (accept edge E0). req while busy SHALL be ignored.
REQ-022 Legal loads SHALL be funct3 000 lb, 001 lh, 010 lw, 100 lbu and 101 lhu; legal stores SHALL be 000 sb, 001 sh and 010 sw; every other code SHALL be an error.
REQ-023 An access SHALL be an error if it is a halfword with addr[0]=1, a word with addr[1:0]!=0, or has addr[31:2] >= DEPTH_WORDS.
REQ-024 Error path: E0 -> RESP, then done=1 and err=1 for one cycle, then IDLE. mem_read and mem_write SHALL stay 0 and rdata SHALL be unchanged.
REQ-025 Load path: E0 -> RD with mem_read=1; at E1, rdata <= the extended lane of mem_rdata and state -> RESP; done=1 in the cycle after E1; IDLE at E2.
REQ-026 Load lane select: byte lane = addr[1:0] (bits 8*k+7:8*k); half lane = addr[1] (bits 16*h+15:16*h). lb and lh SHALL sign-extend; lbu and lhu SHALL zero-extend.
REQ-027 sw path: E0 -> WR with mem_write=1 and mem_wdata=wdata; E1 -> RESP; done in the following cycle.
REQ-028 sb/sh path (read-modify-write): E0 -> RD (mem_read=1); at E1 capture mem_rdata and go to WR; WR drives mem_write=1 with mem_wdata = captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; E2 -> RESP.
REQ-029 mem_read and mem_write SHALL never be high together; both SHALL be 0 in IDLE and RESP.
REQ-030 mem_addr and mem_wdata SHALL be stable for the whole cycle mem_write is high; mem_addr changes only at an accept edge.
REQ-031 done and err SHALL be asserted only in RESP; stores and errors SHALL not modify rdata.
REQ-032 req asserted during the RESP cycle SHALL be ignored; the next request is accepted in IDLE at the earliest.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE and busy=done=err=mem_read=mem_write=0, without waiting for a clock edge.
REQ-034 rst_n=0 SHALL immediately force rdata=0, mem_addr=0 and mem_wdata=0.
REQ-035 Reset mid-operation SHALL abandon the access with no completion pulse; a write strobe cut by reset is permitted to have updated the memory word.
REQ-036 The first accept SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Verification (memory preloaded with word[i]=i)
REQ-037 lw, addr=0x14 -> mem_read for one cycle with mem_addr=5; done 2 cycles after accept; rdata=0x00000005; err=0.
REQ-038 sb, addr=0x09, wdata=0xAB -> RD then WR on mem_addr=2 with mem_wdata=0x0000AB02; done 3 cycles after accept; rdata unchanged.
REQ-039 After REQ-038: lb 0x09 -> rdata=0xFFFFFFAB; lbu 0x09 -> rdata=0x000000AB; lh 0x0A -> 0x00000000; lhu 0x08 -> 0x0000AB02.
REQ-040 lw 0x06, sh 0x03, funct3=011, or lw 0x200 -> done=1 and err=1 one cycle after accept; no memory strobes; rdata unchanged.
REQ-041 sh 0x04 with wdata=0xBEEF, rst_n pulsed low during WR -> outputs go to reset values at once and no done pulse; a following lw 0x04 completes normally.
REQ-042 req held high continuously -> accepts spaced by the full path latency, no accept while busy, each access yields exactly one done pulse.
